memory_controller: RTL and testbench

Backing-memory responder for the pipelined nand_cpu: the servicing end of the cache-request channels issued by the instruction cache (fetch stage) and data cache (action stage). It arbitrates between the two requesters, models a fixed-latency line store, and returns a one-cycle response pulse to the granted requester. It replaces the previous untimed memory model so that cache-miss stalls in the hazard controller see realistic latency.

---
 rtl/memory_controller.sv | 113 +++++++++++
 tb/tb_memory_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// memory_controller: arbitrated fixed-latency line store serving I-cache and D-cache fills; `MEMORY_CONTROLLER_RR_EN selects round-robin ties.
// Latency: response pulse LATENCY+1 cycles after the request is first seen in IDLE; one transaction per LATENCY+2 cycles.
// Backpressure: requests are held by the caches; anything valid while busy waits and is sampled in the next IDLE cycle.
module memory_controller #(
  parameter int LINE_AW = 6,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_req_valid,
  input  logic [LINE_AW-1:0] i_req_addr,
  output logic               i_resp_valid,
  output logic [LINE_W-1:0]  i_resp_data,
  input  logic               d_req_valid,
  input  logic               d_req_write,
  input  logic [LINE_AW-1:0] d_req_addr,
  input  logic [LINE_W-1:0]  d_req_wdata,
  output logic               d_resp_valid,
  output logic [LINE_W-1:0]  d_resp_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               owner_d;
  logic               lat_write;
  logic [LINE_AW-1:0] lat_addr;
  logic [LINE_W-1:0]  lat_wdata;
  logic               grant_d;

  logic [LINE_W-1:0]  store [2**LINE_AW];

`ifdef MEMORY_CONTROLLER_RR_EN
  logic last_grant_d;

  // On a tie the requester that did not win last time takes the grant.
  always_comb grant_d = d_req_valid && (!i_req_valid || !last_grant_d);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (i_req_valid || d_req_valid)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  always_comb grant_d = d_req_valid;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      owner_d      <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      busy         <= 1'b0;
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid || d_req_valid) begin
            owner_d   <= grant_d;
            lat_addr  <= grant_d ? d_req_addr : i_req_addr;
            lat_write <= grant_d && d_req_write;
            lat_wdata <= d_req_wdata;
            cnt       <= 4'(LATENCY - 1);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // The store cannot change before RESP, so reading here yields the pre-write line.
            i_resp_valid <= !owner_d;
            d_resp_valid <= owner_d;
            i_resp_data  <= owner_d ? '0 : store[lat_addr];
            d_resp_data  <= owner_d ? store[lat_addr] : '0;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          i_resp_valid <= 1'b0;
          d_resp_valid <= 1'b0;
          i_resp_data  <= '0;
          d_resp_data  <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // No reset here: an asynchronous reset leaves RESP before the edge, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_write) begin
      store[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed cases from the behaviour rules plus random two-requester traffic
// against a transaction-level model (cycle arithmetic and a line array).
module tb_memory_controller;

  localparam int AW  = 6;
  localparam int W   = 64;
  localparam int LAT = 3;
  localparam logic [W-1:0] PAT = 64'h1122334455667788;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_resp_valid;
  logic [W-1:0]  i_resp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_write = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic [W-1:0]  d_req_wdata = '0;
  logic          d_resp_valid;
  logic [W-1:0]  d_resp_data;
  logic          busy;

  logic          f_i_req_valid = 1'b0;
  logic [AW-1:0] f_i_req_addr = '0;
  logic          f_i_resp_valid;
  logic [W-1:0]  f_i_resp_data;
  logic          f_d_req_valid = 1'b0;
  logic          f_d_req_write = 1'b0;
  logic [AW-1:0] f_d_req_addr = '0;
  logic [W-1:0]  f_d_req_wdata = '0;
  logic          f_d_resp_valid;
  logic [W-1:0]  f_d_resp_data;
  logic          f_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit data_known = 1'b0;

  memory_controller #(.LINE_AW(AW), .LINE_W(W), .LATENCY(LAT)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .busy(busy)
  );

  memory_controller #(.LINE_AW(AW), .LINE_W(W), .LATENCY(1)) u_fast (
    .clk(clk), .n_rst(n_rst),
    .i_req_valid(f_i_req_valid), .i_req_addr(f_i_req_addr),
    .i_resp_valid(f_i_resp_valid), .i_resp_data(f_i_resp_data),
    .d_req_valid(f_d_req_valid), .d_req_write(f_d_req_write),
    .d_req_addr(f_d_req_addr), .d_req_wdata(f_d_req_wdata),
    .d_resp_valid(f_d_resp_valid), .d_resp_data(f_d_resp_data),
    .busy(f_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: one outstanding transaction with an absolute response cycle.
  logic [W-1:0]  mem_m [2**AW];
  bit            m_pend = 1'b0;
  bit            m_own_d = 1'b0;
  bit            m_wr = 1'b0;
  bit            m_last_d = 1'b0;
  int            m_resp_cyc = 0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_wd = '0;

  initial foreach (mem_m[a]) mem_m[a] = '0;

  always @(negedge clk) begin : compare
    bit resp_now;
    bit tie;
    bit gd;
    logic [W-1:0] rd;
    if (!n_rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_i_valid", i_resp_valid, 0);
      chk("rst_d_valid", d_resp_valid, 0);
      chk("rst_i_data", i_resp_data, 0);
      chk("rst_d_data", d_resp_data, 0);
      m_pend   = 1'b0;
      m_last_d = 1'b0;
    end else begin
      resp_now = m_pend && (m_resp_cyc == cyc);
      rd = mem_m[m_addr];
      chk("busy", busy, m_pend);
      chk("i_valid", i_resp_valid, resp_now && !m_own_d);
      chk("d_valid", d_resp_valid, resp_now && m_own_d);
      if (data_known) begin
        chk("i_data", i_resp_data, (resp_now && !m_own_d) ? rd : '0);
        chk("d_data", d_resp_data, (resp_now && m_own_d) ? rd : '0);
      end
      if (resp_now) begin
        if (m_wr) mem_m[m_addr] = m_wd;
        m_pend = 1'b0;
      end else if (!m_pend && (i_req_valid || d_req_valid)) begin
        tie = i_req_valid && d_req_valid;
`ifdef MEMORY_CONTROLLER_RR_EN
        gd = tie ? !m_last_d : d_req_valid;
`else
        gd = tie ? 1'b1 : d_req_valid;
`endif
        m_pend     = 1'b1;
        m_own_d    = gd;
        m_last_d   = gd;
        m_addr     = gd ? d_req_addr : i_req_addr;
        m_wr       = gd && d_req_write;
        m_wd       = d_req_wdata;
        m_resp_cyc = cyc + LAT + 1;
      end
    end
  end

  // Waits for the chosen requester's response; k counts cycles from the current one.
  task automatic wait_resp(input bit is_d, input bit wig, output int k, output logic [W-1:0] dat, output bit got);
    k = 0; got = 1'b0; dat = '0;
    while (!got && k < 200) begin
      @(negedge clk);
      if (is_d ? d_resp_valid : i_resp_valid) begin
        got = 1'b1;
        dat = is_d ? d_resp_data : i_resp_data;
      end else begin
        k++;
        if (wig && is_d && m_pend && m_own_d && $urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
          d_req_addr  = AW'($urandom);
          d_req_wdata = {$urandom, $urandom};
          d_req_write = 1'($urandom);
          k++;
        end
      end
    end
    if (!got) chk("resp_timeout", 64'(got), 1);
  endtask

  task automatic req(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                     output int k, output logic [W-1:0] dat);
    bit got;
    if (is_d) begin
      d_req_write = wr; d_req_addr = a; d_req_wdata = wd; d_req_valid = 1'b1;
    end else begin
      i_req_addr = a; i_req_valid = 1'b1;
    end
    wait_resp(is_d, 1'b0, k, dat, got);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic drive_rand(input bit is_d, input int n_tx);
    int k;
    int gap;
    bit got;
    logic [W-1:0] dat;
    for (int n = 0; n < n_tx; n++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        if (is_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      if (is_d) begin
        d_req_write = 1'($urandom);
        d_req_addr  = AW'($urandom_range(0, 7));
        d_req_wdata = {$urandom, $urandom};
        d_req_valid = 1'b1;
      end else begin
        i_req_addr  = AW'($urandom_range(0, 7));
        i_req_valid = 1'b1;
      end
      wait_resp(is_d, 1'b1, k, dat, got);
      @(posedge clk); #1;
    end
    if (is_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin : stim
    int k;
    bit got;
    bit who;
    logic [W-1:0] dat;
    logic [2:0] tie_exp;

    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    // Power-up line contents are not guaranteed by every simulator: write zeros first.
    for (int a = 0; a < 2**AW; a++) req(1'b1, 1'b1, AW'(a), '0, k, dat);

    do_reset();
    data_known = 1'b1;

    req(1'b1, 1'b1, 6'd5, PAT, k, dat);
    chk("wr5_latency", 64'(k), 4);
    chk("wr5_prior_data", dat, 0);
    chk("wr5_busy_after", busy, 0);

    req(1'b0, 1'b0, 6'd5, '0, k, dat);
    chk("rd5_latency", 64'(k), 4);
    chk("rd5_data", dat, PAT);

    d_req_write = 1'b0; d_req_addr = 6'd5; d_req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req_addr = 6'd9; d_req_wdata = '1; d_req_write = 1'b1;
    wait_resp(1'b1, 1'b0, k, dat, got);
    chk("addr_change_latency", 64'(k), 2);
    chk("addr_change_data", dat, PAT);
    @(posedge clk); #1;
    d_req_valid = 1'b0;

    d_req_write = 1'b1; d_req_addr = 6'd7; d_req_wdata = 64'hdeadbeefcafef00d; d_req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0; d_req_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_d_valid", d_resp_valid, 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    req(1'b1, 1'b0, 6'd7, '0, k, dat);
    chk("abort_rd7_data", dat, 0);

    do_reset();
`ifdef MEMORY_CONTROLLER_RR_EN
    tie_exp = 3'b101;
`else
    tie_exp = 3'b111;
`endif
    d_req_write = 1'b0; d_req_addr = 6'd1; d_req_valid = 1'b1;
    i_req_addr = 6'd2; i_req_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      got = 1'b0; k = 0;
      while (!got && k < 50) begin
        @(negedge clk);
        if (i_resp_valid || d_resp_valid) got = 1'b1; else k++;
      end
      who = d_resp_valid;
      chk("tie_got", 64'(got), 1);
      chk($sformatf("tie_grant_%0d", r), 64'(who), 64'(tie_exp[2-r]));
      @(posedge clk); #1;
      if (who) d_req_addr = d_req_addr + 6'd1; else i_req_addr = i_req_addr + 6'd1;
    end
    d_req_valid = 1'b0;
    wait_resp(1'b0, 1'b0, k, dat, got);
    chk("tie_i_served", 64'(got), 1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;

    fork
      drive_rand(1'b0, 40);
      drive_rand(1'b1, 40);
    join
    repeat (LAT + 3) @(posedge clk);
    #1;

    for (int a = 0; a < 2; a++) begin
      f_d_req_write = 1'b1; f_d_req_addr = AW'(a);
      f_d_req_wdata = (a == 0) ? 64'h0a0a0a0a0a0a0a0a : 64'hb1b1b1b1b1b1b1b1;
      f_d_req_valid = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 50) begin
        @(negedge clk);
        if (f_d_resp_valid) got = 1'b1; else k++;
      end
      chk("fast_wr_latency", 64'(k), 2);
      @(posedge clk); #1;
      f_d_req_valid = 1'b0;
    end
    f_i_req_addr = 6'd0; f_i_req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("fast_i_valid_c%0d", c), f_i_resp_valid, (c == 2 || c == 5));
      if (c == 2) begin
        chk("fast_rd0_data", f_i_resp_data, 64'h0a0a0a0a0a0a0a0a);
        @(posedge clk); #1;
        f_i_req_addr = 6'd1;
      end
      if (c == 5) chk("fast_rd1_data", f_i_resp_data, 64'hb1b1b1b1b1b1b1b1);
    end
    @(posedge clk); #1;
    f_i_req_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
